pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Pipeline stall/flush sequencer for the five-stage core. It turns the ID-stage load-use request and EX-stage multi-cycle operations (two-phase multiply-accumulate, iterative divide) into the 6-bit `stall` vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also drives the divider start/cancel handshake and counts stall cycles for performance monitoring.

## Interface
- `DIV_TIMEOUT`, 40: maximum DIV_BUSY cycles before forced completion with error.
- `PERF_W`, 32: width of the stall-cycle counter.
- `clk` in 1: core clock; all state updates on its rising edge.
- `rst` in 1: synchronous reset, active-low (asserted when `rst`=0).
- `stallreq_id` in 1: load-use hazard detected in ID.
- `ex_mc_op` in 2: EX multi-cycle op class. 00 none, 01 madd/msub, 10 div, 11 reserved (treated as none).
- `flush` in 1: abort the in-flight multi-cycle op (exception/redirect).
- `div_done` in 1: divider result valid, single-cycle pulse.
- `stall` out 6: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop.
- `madd_phase` out 1: 0 = first accumulate phase, 1 = second phase (to EX).
- `div_start` out 1: one-cycle start pulse to the divider.
- `div_cancel` out 1: one-cycle abort pulse to the divider.
- `div_err` out 1: one-cycle pulse when the divide times out.
- `mc_busy` out 1: high in any state other than IDLE.
- `stall_cycles` out PERF_W: count of cycles with `stall`≠0.

## Operation
- FSM states: IDLE, MADD2, DIV_BUSY, DIV_FIN. `stall`, `div_start`, `div_cancel`, `madd_phase` and `div_err` are combinational from state and inputs. State, timeout counter and `stall_cycles` are registered.
- Priority in every state: `flush` > EX request > `stallreq_id`.
- IDLE:
  - `flush` → stall 000000, stay.
  - `ex_mc_op`=01 → stall 001111, `madd_phase`=0, next MADD2.
  - `ex_mc_op`=10 → stall 001111, `div_start`=1, clear timeout counter, next DIV_BUSY.
  - Otherwise `stallreq_id` → stall 000111.
  - Otherwise stall 000000.
- MADD2: stall 000000, `madd_phase`=1, next IDLE. `ex_mc_op` is ignored.
- DIV_BUSY:
  - stall 001111; timeout counter increments each cycle.
  - `div_done` → next DIV_FIN.
  - Counter = DIV_TIMEOUT−1 without `div_done` → `div_err`=1, `div_cancel`=1, next DIV_FIN.
  - `div_done` and timeout in the same cycle → `div_done` wins, no error.
- DIV_FIN: stall 000000, next IDLE. EX captures the quotient/remainder this cycle.
- `flush` in MADD2, DIV_BUSY or DIV_FIN → stall 000000, next IDLE. In DIV_BUSY, `div_cancel`=1 as well, including when `div_done` arrives in the same cycle.
- `stallreq_id` is ignored outside IDLE; the EX stall already covers it.
- `stall_cycles` increments whenever `stall`≠0 and wraps from all-ones to 0.
- Reset (any state, mid-divide included):
  - state IDLE, timeout counter 0, `stall_cycles` 0.
  - All outputs 0 during reset: `stall`=000000, pulses low, `madd_phase`=0, `mc_busy`=0.
  - No `div_cancel` is issued; the divider is reset by the same `rst`.

## Timing
- Zero-cycle response: `stall` reflects same-cycle inputs, so the pipeline registers hold on the next edge.
- madd/msub: EX is held for exactly 1 extra cycle, 2 EX cycles in total.
- div: `div_start` is asserted in cycle 0. Stall lasts from cycle 0 until the cycle in which `div_done` is sampled, inclusive. Release happens in DIV_FIN one cycle later.
- Back-to-back divides: IDLE accepts a new `ex_mc_op`=10 the cycle after DIV_FIN.
- `mc_busy` is registered state decode, high from the cycle after entry through DIV_FIN/MADD2.

## Structure
- Shared define file, not local to this block:
  - stall encodings `StallNone` 6'b000000, `StallFromId` 6'b000111, `StallFromEx` 6'b001111;
  - `ex_mc_op` codes;
  - FSM state encodings (2 bits);
  - `Stop`/`NoStop`.
- Single flat module. No sub-module is needed; the timeout counter and perf counter are inline registers.

## Test plan
- `rst`=0 for 3 cycles while `ex_mc_op`=10 → `stall`=000000, `div_start`=0, `stall_cycles`=0, `mc_busy`=0.
- IDLE, `stallreq_id`=1 for one cycle → `stall`=000111 that cycle only; `stall_cycles` 0→1.
- `ex_mc_op`=01 → cycle0 `stall`=001111 with `madd_phase`=0; cycle1 `stall`=000000 with `madd_phase`=1; cycle2 IDLE.
- `ex_mc_op`=10 with `div_done` on cycle 33 → `div_start` on cycle0 only; `stall`=001111 cycles 0–33; cycle34 `stall`=000000; `stall_cycles`=34.
- DIV_TIMEOUT=8 and no `div_done` → `div_err` and `div_cancel` pulse on cycle 8, DIV_FIN on cycle 9, then IDLE.
- `flush` on cycle 5 of a divide, coincident with `div_done` → `div_cancel`=1, `stall`=000000 in cycle 5, IDLE in cycle 6, no `div_err`.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline-control definitions: stall vector encodings, EX multi-cycle
// op classes and the stall/flush sequencer state encoding.
package pipe_stall_ctrl_pkg;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // stall bit order: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB
    localparam logic [5:0] StallNone   = 6'b000000;
    localparam logic [5:0] StallFromId = 6'b000111;
    localparam logic [5:0] StallFromEx = 6'b001111;

    localparam logic [1:0] ExOpNone = 2'b00;
    localparam logic [1:0] ExOpMadd = 2'b01;
    localparam logic [1:0] ExOpDiv  = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MADD2    = 2'b01,
        DIV_BUSY = 2'b10,
        DIV_FIN  = 2'b11
    } stall_state_e;

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer: load-use and EX multi-cycle ops (madd, divide) into
// the per-stage stall vector, divider start/cancel handshake and perf count.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned DIV_TIMEOUT = 40,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic [1:0]        ex_mc_op,
    input  logic              flush,
    input  logic              div_done,
    output logic [5:0]        stall,
    output logic              madd_phase,
    output logic              div_start,
    output logic              div_cancel,
    output logic              div_err,
    output logic              mc_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int unsigned     TW       = $clog2(DIV_TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(DIV_TIMEOUT - 1);

    stall_state_e      state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [PERF_W-1:0] cyc_q;

    // Outputs are forced low while rst is held, independent of the registers.
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        stall      = StallNone;
        madd_phase = 1'b0;
        div_start  = 1'b0;
        div_cancel = 1'b0;
        div_err    = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_d = IDLE;
                    end else if (ex_mc_op == ExOpMadd) begin
                        stall   = StallFromEx;
                        state_d = MADD2;
                    end else if (ex_mc_op == ExOpDiv) begin
                        stall     = StallFromEx;
                        div_start = 1'b1;
                        tmo_d     = '0;
                        state_d   = DIV_BUSY;
                    end else if (stallreq_id) begin
                        stall = StallFromId;
                    end
                end
                MADD2: begin
                    madd_phase = 1'b1;
                    state_d    = IDLE;
                end
                DIV_BUSY: begin
                    if (flush) begin
                        div_cancel = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        stall = StallFromEx;
                        tmo_d = tmo_q + 1'b1;
                        // A done pulse on the last allowed cycle still counts as success.
                        if (div_done) begin
                            state_d = DIV_FIN;
                        end else if (tmo_q == TMO_LAST) begin
                            div_err    = 1'b1;
                            div_cancel = 1'b1;
                            state_d    = DIV_FIN;
                        end
                    end
                end
                DIV_FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (stall != StallNone) begin
                cyc_q <= cyc_q + 1'b1;
            end
        end
    end

    assign mc_busy      = rst && (state_q != IDLE);
    assign stall_cycles = cyc_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a default instance plus a short-timeout,
// narrow-counter instance sharing the same inputs.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id;
    logic [1:0]  ex_mc_op;
    logic        flush;
    logic        div_done;

    logic [5:0]  stall;
    logic        madd_phase, div_start, div_cancel, div_err, mc_busy;
    logic [31:0] stall_cycles;

    logic [5:0]  t_stall;
    logic        t_madd, t_start, t_cancel, t_err, t_busy;
    logic [3:0]  t_cycles;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.DIV_TIMEOUT(40), .PERF_W(32)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_op(ex_mc_op),
        .flush(flush), .div_done(div_done), .stall(stall), .madd_phase(madd_phase),
        .div_start(div_start), .div_cancel(div_cancel), .div_err(div_err),
        .mc_busy(mc_busy), .stall_cycles(stall_cycles)
    );

    pipe_stall_ctrl #(.DIV_TIMEOUT(8), .PERF_W(4)) dut8 (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_op(ex_mc_op),
        .flush(flush), .div_done(div_done), .stall(t_stall), .madd_phase(t_madd),
        .div_start(t_start), .div_cancel(t_cancel), .div_err(t_err),
        .mc_busy(t_busy), .stall_cycles(t_cycles)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        stallreq_id = 1'b0;
        ex_mc_op    = 2'b00;
        flush       = 1'b0;
        div_done    = 1'b0;
    endtask

    // Leaves the bench 1 time unit after an edge with rst released, DUTs in IDLE.
    task automatic do_reset;
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        clear_inputs();
        ex_mc_op = 2'b10;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            vec++;
            if (stall !== 6'b000000 || div_start !== 1'b0 || mc_busy !== 1'b0) begin
                errs++;
                $display("FAIL reset_outputs cyc%0d stall=%b start=%b busy=%b, want 000000/0/0",
                         c, stall, div_start, mc_busy);
            end
        end
        vec++;
        if (stall_cycles !== 32'd0) begin
            errs++;
            $display("FAIL reset_perf got %0d want 0", stall_cycles);
        end
        clear_inputs();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_load_use;
        do_reset();
        stallreq_id = 1'b1;
        #1;
        vec++;
        if (stall !== 6'b000111) begin
            errs++;
            $display("FAIL loaduse_stall got %b want 000111", stall);
        end
        tick();
        stallreq_id = 1'b0;
        #1;
        vec++;
        if (stall !== 6'b000000 || stall_cycles !== 32'd1 || mc_busy !== 1'b0) begin
            errs++;
            $display("FAIL loaduse_release stall=%b perf=%0d busy=%b, want 000000/1/0",
                     stall, stall_cycles, mc_busy);
        end
    endtask

    task automatic test_madd;
        do_reset();
        ex_mc_op = 2'b01;
        #1;
        vec++;
        if (stall !== 6'b001111 || madd_phase !== 1'b0) begin
            errs++;
            $display("FAIL madd_c0 stall=%b phase=%b, want 001111/0", stall, madd_phase);
        end
        tick();
        stallreq_id = 1'b1;
        #1;
        vec++;
        if (stall !== 6'b000000 || madd_phase !== 1'b1 || mc_busy !== 1'b1) begin
            errs++;
            $display("FAIL madd_c1 stall=%b phase=%b busy=%b, want 000000/1/1",
                     stall, madd_phase, mc_busy);
        end
        tick();
        clear_inputs();
        #1;
        vec++;
        if (mc_busy !== 1'b0 || madd_phase !== 1'b0 || stall_cycles !== 32'd1) begin
            errs++;
            $display("FAIL madd_c2 busy=%b phase=%b perf=%0d, want 0/0/1",
                     mc_busy, madd_phase, stall_cycles);
        end
    endtask

    task automatic test_div;
        do_reset();
        ex_mc_op = 2'b10;
        #1;
        vec++;
        if (div_start !== 1'b1 || stall !== 6'b001111) begin
            errs++;
            $display("FAIL div_c0 start=%b stall=%b, want 1/001111", div_start, stall);
        end
        for (int c = 1; c <= 33; c++) begin
            tick();
            ex_mc_op = 2'b00;
            div_done = (c == 33);
            #1;
            vec++;
            if (stall !== 6'b001111 || div_start !== 1'b0 || mc_busy !== 1'b1) begin
                errs++;
                $display("FAIL div_busy cyc%0d stall=%b start=%b busy=%b, want 001111/0/1",
                         c, stall, div_start, mc_busy);
            end
        end
        tick();
        div_done = 1'b0;
        #1;
        vec++;
        if (stall !== 6'b000000 || mc_busy !== 1'b1 || stall_cycles !== 32'd34 || div_err !== 1'b0) begin
            errs++;
            $display("FAIL div_fin stall=%b busy=%b perf=%0d err=%b, want 000000/1/34/0",
                     stall, mc_busy, stall_cycles, div_err);
        end
    endtask

    // Runs straight after test_div: the cycle after DIV_FIN is IDLE again.
    task automatic test_back_to_back;
        tick();
        ex_mc_op = 2'b10;
        #1;
        vec++;
        if (div_start !== 1'b1 || mc_busy !== 1'b0 || stall !== 6'b001111) begin
            errs++;
            $display("FAIL b2b_start start=%b busy=%b stall=%b, want 1/0/001111",
                     div_start, mc_busy, stall);
        end
        tick();
        ex_mc_op = 2'b00;
        flush    = 1'b1;
        #1;
        vec++;
        if (div_cancel !== 1'b1 || stall !== 6'b000000) begin
            errs++;
            $display("FAIL b2b_flush cancel=%b stall=%b, want 1/000000", div_cancel, stall);
        end
        tick();
        flush = 1'b0;
        #1;
        vec++;
        if (mc_busy !== 1'b0 || stall_cycles !== 32'd35) begin
            errs++;
            $display("FAIL b2b_idle busy=%b perf=%0d, want 0/35", mc_busy, stall_cycles);
        end
    endtask

    task automatic test_flush_done;
        do_reset();
        ex_mc_op = 2'b10;
        for (int c = 1; c <= 5; c++) begin
            tick();
            ex_mc_op = 2'b00;
        end
        flush    = 1'b1;
        div_done = 1'b1;
        #1;
        vec++;
        if (div_cancel !== 1'b1 || stall !== 6'b000000 || div_err !== 1'b0) begin
            errs++;
            $display("FAIL flushdone_c5 cancel=%b stall=%b err=%b, want 1/000000/0",
                     div_cancel, stall, div_err);
        end
        tick();
        clear_inputs();
        #1;
        vec++;
        if (mc_busy !== 1'b0 || stall !== 6'b000000 || stall_cycles !== 32'd5) begin
            errs++;
            $display("FAIL flushdone_c6 busy=%b stall=%b perf=%0d, want 0/000000/5",
                     mc_busy, stall, stall_cycles);
        end
    endtask

    task automatic test_idle_misc;
        do_reset();
        flush    = 1'b1;
        ex_mc_op = 2'b10;
        #1;
        vec++;
        if (stall !== 6'b000000 || div_start !== 1'b0) begin
            errs++;
            $display("FAIL idle_flush stall=%b start=%b, want 000000/0", stall, div_start);
        end
        tick();
        flush    = 1'b0;
        ex_mc_op = 2'b11;
        #1;
        vec++;
        if (stall !== 6'b000000 || mc_busy !== 1'b0 || div_start !== 1'b0) begin
            errs++;
            $display("FAIL idle_reserved stall=%b busy=%b start=%b, want 000000/0/0",
                     stall, mc_busy, div_start);
        end
        tick();
        clear_inputs();
        #1;
        vec++;
        if (mc_busy !== 1'b0 || stall_cycles !== 32'd0) begin
            errs++;
            $display("FAIL idle_after busy=%b perf=%0d, want 0/0", mc_busy, stall_cycles);
        end
    endtask

    task automatic test_timeout;
        do_reset();
        ex_mc_op = 2'b10;
        for (int c = 1; c <= 7; c++) begin
            tick();
            ex_mc_op = 2'b00;
            #1;
            vec++;
            if (t_err !== 1'b0 || t_cancel !== 1'b0) begin
                errs++;
                $display("FAIL tmo_early cyc%0d err=%b cancel=%b, want 0/0", c, t_err, t_cancel);
            end
        end
        tick();
        #1;
        vec++;
        if (t_err !== 1'b1 || t_cancel !== 1'b1 || t_stall !== 6'b001111) begin
            errs++;
            $display("FAIL tmo_c8 err=%b cancel=%b stall=%b, want 1/1/001111",
                     t_err, t_cancel, t_stall);
        end
        tick();
        #1;
        vec++;
        if (t_busy !== 1'b1 || t_stall !== 6'b000000 || t_err !== 1'b0) begin
            errs++;
            $display("FAIL tmo_c9 busy=%b stall=%b err=%b, want 1/000000/0", t_busy, t_stall, t_err);
        end
        tick();
        #1;
        vec++;
        if (t_busy !== 1'b0) begin
            errs++;
            $display("FAIL tmo_c10 busy=%b want 0", t_busy);
        end
    endtask

    task automatic test_timeout_vs_done;
        do_reset();
        ex_mc_op = 2'b10;
        for (int c = 1; c <= 8; c++) begin
            tick();
            ex_mc_op = 2'b00;
            div_done = (c == 8);
        end
        #1;
        vec++;
        if (t_err !== 1'b0 || t_cancel !== 1'b0 || t_stall !== 6'b001111) begin
            errs++;
            $display("FAIL tmodone_c8 err=%b cancel=%b stall=%b, want 0/0/001111",
                     t_err, t_cancel, t_stall);
        end
        tick();
        div_done = 1'b0;
        #1;
        vec++;
        if (t_busy !== 1'b1 || t_stall !== 6'b000000 || t_cycles !== 4'd9) begin
            errs++;
            $display("FAIL tmodone_c9 busy=%b stall=%b perf=%0d, want 1/000000/9",
                     t_busy, t_stall, t_cycles);
        end
    endtask

    task automatic test_perf_wrap;
        do_reset();
        stallreq_id = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
        end
        #1;
        vec++;
        if (t_cycles !== 4'd0) begin
            errs++;
            $display("FAIL perf_wrap16 got %0d want 0", t_cycles);
        end
        tick();
        stallreq_id = 1'b0;
        #1;
        vec++;
        if (t_cycles !== 4'd1 || stall_cycles !== 32'd17) begin
            errs++;
            $display("FAIL perf_wrap17 narrow=%0d wide=%0d, want 1/17", t_cycles, stall_cycles);
        end
    endtask

    task automatic test_reset_mid_div;
        do_reset();
        ex_mc_op = 2'b10;
        for (int c = 1; c <= 3; c++) begin
            tick();
            ex_mc_op = 2'b00;
        end
        rst = 1'b0;
        #1;
        vec++;
        if (stall !== 6'b000000 || div_cancel !== 1'b0 || mc_busy !== 1'b0 || div_err !== 1'b0) begin
            errs++;
            $display("FAIL rstmid_comb stall=%b cancel=%b busy=%b err=%b, want 000000/0/0/0",
                     stall, div_cancel, mc_busy, div_err);
        end
        tick();
        rst = 1'b1;
        #1;
        vec++;
        if (mc_busy !== 1'b0 || stall_cycles !== 32'd0 || stall !== 6'b000000) begin
            errs++;
            $display("FAIL rstmid_after busy=%b perf=%0d stall=%b, want 0/0/000000",
                     mc_busy, stall_cycles, stall);
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_madd();
        test_div();
        test_back_to_back();
        test_flush_done();
        test_idle_misc();
        test_timeout();
        test_timeout_vs_done();
        test_perf_wrap();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim time exceeded, got no finish want finish");
        $fatal(1);
    end

endmodule
